// File: rtl/fact_pkg.sv
// Shared constants for the memory-mapped factorial accelerator: register map,
// core state encoding and the largest operand whose factorial fits in 32 bits.
package fact_pkg;

    localparam logic [1:0] FACT_N      = 2'd0;
    localparam logic [1:0] FACT_GO     = 2'd1;
    localparam logic [1:0] FACT_STATUS = 2'd2;
    localparam logic [1:0] FACT_RESULT = 2'd3;

    localparam logic [3:0] FACT_NMAX = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DONE = 2'd2
    } fact_state_e;

endpackage

// File: rtl/fact_accel_mmio_if.sv
// Data-memory bus slice seen by the factorial accelerator: qualified write
// strobe, word select, write data and combinational read data.
interface fact_accel_mmio_if;
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output we, output a, output wd, input rd);
    modport slave  (input we, input a, input wd, output rd);
endinterface

// File: rtl/fact_core.sv
// Iterative factorial engine: one multiply per clock, counting the latched
// operand down to the terminal value 1.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start after reset
// ST_MULT | prod accumulates prod*cnt while cnt counts down
// ST_DONE | result/done/err held; a new start restarts the computation
module fact_core
    import fact_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  n,
    output logic        done,
    output logic        err,
    output logic [31:0] result
);

    fact_state_e state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] prod, prod_nxt;
    logic [31:0] result_nxt;
    logic        done_nxt, err_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            prod   <= 32'd0;
            result <= 32'd0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            prod   <= prod_nxt;
            result <= result_nxt;
            done   <= done_nxt;
            err    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        prod_nxt   = prod;
        result_nxt = result;
        done_nxt   = done;
        err_nxt    = err;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    cnt_nxt  = n;
                    prod_nxt = 32'd1;
                    done_nxt = 1'b0;
                    err_nxt  = 1'b0;
                    // Operands past 12! would overflow 32 bits: flag and finish at once.
                    if (n > FACT_NMAX) begin
                        state_nxt  = ST_DONE;
                        err_nxt    = 1'b1;
                        done_nxt   = 1'b1;
                        result_nxt = 32'd0;
                    end else begin
                        state_nxt = ST_MULT;
                    end
                end
            end
            ST_MULT: begin
                if (cnt <= 4'd1) begin
                    result_nxt = prod;
                    done_nxt   = 1'b1;
                    state_nxt  = ST_DONE;
                end else begin
                    prod_nxt = prod * {28'd0, cnt};
                    cnt_nxt  = cnt - 4'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/fact_accel_mmio.sv
// Bus responder for the factorial accelerator: holds the N register, decodes
// writes into a start pulse and muxes the register view onto rd.
module fact_accel_mmio
    import fact_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    fact_accel_mmio_if.slave bus
);

    logic [3:0]  n_reg;
    logic        start;
    logic        done;
    logic        err;
    logic [31:0] result;

    // GO is a one-edge strobe, so the pending bit is never observable as 1.
    assign start = bus.we && (bus.a == FACT_GO) && bus.wd[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            n_reg <= 4'd0;
        end else if (bus.we && (bus.a == FACT_N)) begin
            n_reg <= bus.wd[3:0];
        end
    end

    fact_core u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .n      (n_reg),
        .done   (done),
        .err    (err),
        .result (result)
    );

    always_comb begin
        bus.rd = 32'd0;
        case (bus.a)
            FACT_N:      bus.rd = {28'd0, n_reg};
            FACT_GO:     bus.rd = 32'd0;
            FACT_STATUS: bus.rd = {30'd0, err, done};
            FACT_RESULT: bus.rd = result;
            default:     bus.rd = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_fact_accel_mmio.sv
// Directed bench for the factorial accelerator: bus writes/reads with
// hand-computed expected values checked by immediate assertions.
module tb_fact_accel_mmio;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fact_accel_mmio_if bus ();

    fact_accel_mmio dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd_reg(input logic [1:0] addr, output logic [31:0] val);
        bus.a = addr;
        #1;
        val = bus.rd;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        rd_reg(addr, v);
        check(tag, v, exp);
    endtask

    // One write = one rising edge; returns 1ns after that edge.
    task automatic wr_reg(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.we = 1'b1;
        bus.a  = addr;
        bus.wd = data;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        bus.wd = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write N, then GO at edge k; STATUS must stay 0 until edge k+lat.
    task automatic run_fact(input string tag, input logic [31:0] n, input int lat,
                            input logic [31:0] exp_result);
        wr_reg(2'd0, n);
        wr_reg(2'd1, 32'd1);
        for (int i = 1; i < lat; i++) begin
            check({tag, "_busy"}, 32'(dut.bus.rd & 32'd0) | 32'd0, 32'd0);
            check_reg({tag, "_status_busy"}, 2'd2, 32'd0);
            tick();
        end
        if (lat >= 1) begin
            check_reg({tag, "_status_pre"}, 2'd2, 32'd0);
            tick();
        end
        check_reg({tag, "_status_done"}, 2'd2, 32'd1);
        check_reg({tag, "_result"}, 2'd3, exp_result);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.we = 1'b0;
        bus.a  = 2'd0;
        bus.wd = 32'd0;
        repeat (2) tick();
        @(negedge clk);
        rst = 1'b0;
        tick();

        check_reg("rst_n", 2'd0, 32'd0);
        check_reg("rst_go", 2'd1, 32'd0);
        check_reg("rst_status", 2'd2, 32'd0);
        check_reg("rst_result", 2'd3, 32'd0);

        // N stores only bits [3:0]
        wr_reg(2'd0, 32'hFFFF_FFF5);
        check_reg("n_mask", 2'd0, 32'd5);

        run_fact("n5", 32'd5, 5, 32'd120);
        check_reg("go_reads0", 2'd1, 32'd0);

        // Writes to STATUS/RESULT and GO with wd[0]=0 change nothing
        wr_reg(2'd2, 32'hFFFF_FFFF);
        wr_reg(2'd3, 32'hDEAD_BEEF);
        wr_reg(2'd1, 32'd2);
        tick();
        check_reg("ro_status", 2'd2, 32'd1);
        check_reg("ro_result", 2'd3, 32'd120);

        // n=0: result holds 120 until the done edge
        wr_reg(2'd0, 32'd0);
        wr_reg(2'd1, 32'd1);
        check_reg("n0_status_k", 2'd2, 32'd0);
        check_reg("n0_result_hold", 2'd3, 32'd120);
        tick();
        check_reg("n0_status", 2'd2, 32'd1);
        check_reg("n0_result", 2'd3, 32'd1);

        run_fact("n1", 32'd1, 1, 32'd1);
        run_fact("n12", 32'd12, 12, 32'h1C8C_FC00);

        // n=13: error after one edge
        wr_reg(2'd0, 32'd13);
        wr_reg(2'd1, 32'd1);
        check_reg("n13_status", 2'd2, 32'd3);
        check_reg("n13_result", 2'd3, 32'd0);
        check_reg("n13_nread", 2'd0, 32'd13);
        tick();
        check_reg("n13_sticky", 2'd2, 32'd3);
        run_fact("n3", 32'd3, 3, 32'd6);

        // n=6 with N and GO writes mid-computation (GO at edge k)
        wr_reg(2'd0, 32'd6);
        wr_reg(2'd1, 32'd1);
        wr_reg(2'd0, 32'd2);   // edge k+1
        wr_reg(2'd1, 32'd1);   // edge k+2, ignored
        repeat (3) tick();     // edge k+5
        check_reg("mid_status_k5", 2'd2, 32'd0);
        tick();                // edge k+6
        check_reg("mid_status_k6", 2'd2, 32'd1);
        check_reg("mid_result", 2'd3, 32'd720);
        check_reg("mid_nread", 2'd0, 32'd2);
        wr_reg(2'd1, 32'd1);
        check_reg("n2_status_k", 2'd2, 32'd0);
        check_reg("n2_result_hold", 2'd3, 32'd720);
        tick();
        check_reg("n2_status_k1", 2'd2, 32'd0);
        tick();
        check_reg("n2_status", 2'd2, 32'd1);
        check_reg("n2_result", 2'd3, 32'd2);

        // Reset mid-MULT aborts and clears everything
        wr_reg(2'd0, 32'd6);
        wr_reg(2'd1, 32'd1);
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_reg("rstmid_status", 2'd2, 32'd0);
        check_reg("rstmid_result", 2'd3, 32'd0);
        check_reg("rstmid_n", 2'd0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (7) tick();
        check_reg("rstmid_stays_idle", 2'd2, 32'd0);

        // Reset and GO on the same edge: reset wins
        wr_reg(2'd0, 32'd13);
        @(negedge clk);
        rst    = 1'b1;
        bus.we = 1'b1;
        bus.a  = 2'd1;
        bus.wd = 32'd1;
        tick();
        bus.we = 1'b0;
        rst    = 1'b0;
        check_reg("rstgo_status", 2'd2, 32'd0);
        tick();
        check_reg("rstgo_status_next", 2'd2, 32'd0);
        check_reg("rstgo_n", 2'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fact_accel_mmio.md
# fact_accel_mmio

Memory-mapped factorial accelerator that acts as a responder on the MIPS data-memory bus, next to data memory and the GPIO block in `mips_top`. The CPU writes an operand `n` and a go command with ordinary `sw` instructions, polls a status word with `lw`, and then reads the 32-bit result. Computation is iterative, using one multiply per clock, so software observes real busy latency.

## Interface
- No parameters. Register map and widths are fixed constants in the package.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `we`  in  1  write enable, qualified by the system address decoder (CPU `we_dm` AND this block's select).
- `a`  in  2  word-address select, taken from bus address bits [3:2].
- `wd`  in  32  write data (CPU `wd_dm`).
- `rd`  out  32  read data; combinational mux of the register selected by `a`.

## Operation
- Register map by `a`:
  - 0 = N: read/write; bits [3:0] are stored, upper bits read 0.
  - 1 = GO: write-only; reads return `{31'b0, go_pending}`, which is always 0 after the accepting edge.
  - 2 = STATUS: read-only; `{30'b0, err, done}`.
  - 3 = RESULT: read-only.
- Writes to STATUS or RESULT are ignored.
- FSM states: IDLE, MULT, DONE.
- **IDLE**: a GO write with `wd[0]=1` starts a computation.
  - `n` is latched into `cnt`, `prod<=1`, `done<=0`, `err<=0`, and the state goes to MULT.
  - If N > 12 at that edge, the block goes straight to DONE with `err<=1`, `done<=1`, `result<=0`.
- **MULT**, each edge:
  - If `cnt<=1`: `result<=prod`, `done<=1`, state goes to DONE.
  - Otherwise: `prod<=prod*cnt` (low 32 bits; no overflow is possible for n≤12) and `cnt<=cnt-1`.
- **DONE**: `done` and `err` are sticky. A new GO write with `wd[0]=1` restarts exactly as from IDLE.
- Writes with `wd[0]=0` to GO are ignored in every state.
- GO writes while in MULT are ignored; the computation continues undisturbed.
- N writes while in MULT update the N register but do not affect the computation in flight, because `cnt` was latched at start.
- RESULT holds the previous value until the new `done` edge. It is never partially updated.

## Timing
- Reset values: N=0, `done=0`, `err=0`, `result=0`, `prod=0`, `cnt=0`, state IDLE. As a result, `rd` reads 0 at every address after reset.
- The GO write is accepted at edge k.
- `done=1` and RESULT are valid after edge k+max(n,1) for n≤12:
  - n=0 or n=1: after edge k+1.
  - n=5: after edge k+5.
  - n=12: after edge k+12.
- n>12: `done=1`, `err=1` after edge k (one edge).
- `rd` is combinational in `a` and register state. It reflects the new state in the same cycle after an edge, which matches single-cycle `lw` timing.
- A simultaneous `rst` and GO write: reset wins.
- Reset mid-MULT aborts the computation and restores all reset values at that edge.

## Structure
- Package `fact_pkg` holds:
  - register address constants `FACT_N=2'd0`, `FACT_GO=2'd1`, `FACT_STATUS=2'd2`, `FACT_RESULT=2'd3`;
  - FSM state encoding `ST_IDLE`, `ST_MULT`, `ST_DONE`;
  - `FACT_NMAX=4'd12`.
- Sub-module `fact_core`: contains the FSM, `cnt`, `prod`, and the multiplier, with a `start/n/done/err/result` interface.
- The top level `fact_accel_mmio` contains only the N register, write decode, and the read mux.

## Test plan
- Reset, then read all four addresses. Expected `rd = 0` for each.
- Write N=5, write GO=1 at edge k. Poll STATUS: 0 through edge k+4, then 1 after edge k+5; RESULT = 120 (0x78).
- N=0 and then N=1, each followed by GO. Expected `done` after 1 edge, RESULT = 1, `err=0`.
- N=12 then GO. Expected `done` after 12 edges, RESULT = 479001600 (0x1C8CFC00).
- N=13 then GO. Expected STATUS = 3 (`err`, `done`) after 1 edge and RESULT = 0. A following N=3 with GO clears `err` and gives RESULT = 6 after 3 edges.
- Corner cases during N=6 in MULT:
  - Writing N=2 and GO mid-computation: RESULT is still 720, N reads back 2, and the next GO gives 2.
  - A separate run with `rst` asserted mid-MULT: STATUS = 0 and RESULT = 0 at the next edge.
